// File: rtl/alu_9bit_pkg.sv
// Shared types and constants for the 9-bit sign-magnitude datapath.
// Used by sm_addsub_sat_9bit and accumulate_9bit.
package alu_9bit_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] mag;
   } sm9_t;

   localparam logic [7:0] SM_MAG_MAX = 8'd255;
   localparam logic [8:0] SM_ZERO    = 9'h000;

   typedef enum logic {
      ACCUM,
      DONE
   } acc_state_t;

endpackage

// File: rtl/sm_addsub_sat_9bit.sv
// Combinational sign-magnitude add/subtract with magnitude saturation,
// -0 normalisation and a saturation flag.
module sm_addsub_sat_9bit
   import alu_9bit_pkg::*;
(
   input  sm9_t a,
   input  sm9_t b,
   input  logic op,
   output sm9_t y,
   output logic sat
);

   logic       a_sign;
   logic       b_sign;
   logic [8:0] sum;

   // Zero-magnitude operands behave as +0 whatever their sign bit says.
   always_comb begin
      a_sign = (a.mag == 8'd0) ? 1'b0 : a.sign;
      b_sign = (b.mag == 8'd0) ? 1'b0 : (b.sign ^ op);
      sum    = {1'b0, a.mag} + {1'b0, b.mag};
      y      = sm9_t'(SM_ZERO);
      sat    = 1'b0;
      if (a_sign == b_sign) begin
         y.sign = a_sign;
         if (sum[8]) begin
            y.mag = SM_MAG_MAX;
            sat   = 1'b1;
         end else begin
            y.mag = sum[7:0];
         end
      end else if (a.mag > b.mag) begin
         y.sign = a_sign;
         y.mag  = a.mag - b.mag;
      end else begin
         y.sign = b_sign;
         y.mag  = b.mag - a.mag;
      end
      if (y.mag == 8'd0) begin
         y.sign = 1'b0;
      end
   end

endmodule

// File: rtl/accumulate_9bit.sv
// Accumulates LEN sign-magnitude terms and emits the saturated result.
// Optional sticky saturation output out_sat enabled by ACC_OVERFLOW_FLAG_EN.
module accumulate_9bit
   import alu_9bit_pkg::*;
#(
   parameter int LEN = 4
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] in_data,
   input  logic       in_op,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_data,
`ifdef ACC_OVERFLOW_FLAG_EN
   output logic       out_sat,
`endif
   output logic       busy
);

   localparam logic [7:0] LAST = 8'(LEN - 1);

   acc_state_t state;
   sm9_t       acc;
   sm9_t       next_acc;
   logic [7:0] cnt;

   assign in_ready = (state == ACCUM);
   assign busy     = (cnt != 8'd0) || out_valid;

`ifdef ACC_OVERFLOW_FLAG_EN
   logic step_sat;
   logic group_sat;

   sm_addsub_sat_9bit u_addsub (
      .a   (acc),
      .b   (sm9_t'(in_data)),
      .op  (in_op),
      .y   (next_acc),
      .sat (step_sat)
   );
`else
   sm_addsub_sat_9bit u_addsub (
      .a   (acc),
      .b   (sm9_t'(in_data)),
      .op  (in_op),
      .y   (next_acc),
      .sat ()
   );
`endif

   // The accepting edge of the last term loads the result directly, so the
   // output register never needs to wait for acc to settle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         acc       <= sm9_t'(SM_ZERO);
         cnt       <= 8'd0;
         out_valid <= 1'b0;
         out_data  <= SM_ZERO;
`ifdef ACC_OVERFLOW_FLAG_EN
         group_sat <= 1'b0;
         out_sat   <= 1'b0;
`endif
      end else begin
         case (state)
            ACCUM: begin
               if (in_valid) begin
                  acc <= next_acc;
                  if (cnt == LAST) begin
                     state     <= DONE;
                     out_data  <= next_acc;
                     out_valid <= 1'b1;
                     cnt       <= 8'd0;
`ifdef ACC_OVERFLOW_FLAG_EN
                     out_sat   <= group_sat | step_sat;
                     group_sat <= 1'b0;
`endif
                  end else begin
                     cnt <= cnt + 8'd1;
`ifdef ACC_OVERFLOW_FLAG_EN
                     group_sat <= group_sat | step_sat;
`endif
                  end
               end
            end
            DONE: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  acc       <= sm9_t'(SM_ZERO);
                  state     <= ACCUM;
`ifdef ACC_OVERFLOW_FLAG_EN
                  out_sat   <= 1'b0;
`endif
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule
